ic0_axi_master_seq: RTL and testbench

//  Initiator for the ic0 register bus: the requesting end of the link that the

---
 rtl/ic0_axi_master_seq.sv | 145 ++++++++++++++
 tb/tb_ic0_axi_master_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic0_axi_master_seq.sv
// ic0 register-bus initiator: turns single read/write commands into ic0 strobes,
// blocks on reads until a slave returns data or the wait counter times out.
module ic0_axi_master_seq #(
    parameter int unsigned NUM_SLV = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_we_i,
    input  logic [31:0]            cmd_addr_i,
    input  logic [31:0]            cmd_wdata_i,
    output logic                   rsp_valid_o,
    output logic [31:0]            rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   ic0_c_axi_mst_wr_valid_o,
    output logic [31:0]            ic0_axi_mst_wr_addr_o,
    output logic [31:0]            ic0_axi_mst_wr_data_o,
    output logic                   ic0_c_axi_mst_rd_valid_o,
    output logic [31:0]            ic0_axi_mst_rd_addr_o,
    input  logic [NUM_SLV-1:0]     ic0_c_axi_slv_rd_ready_i,
    input  logic [32*NUM_SLV-1:0]  ic0_axi_slv_rd_data_i
);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StWait} state_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            wr_valid_q, wr_valid_d;
    logic [31:0]     wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic [31:0]     rd_addr_q, rd_addr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [31:0]     rd_merged;
    logic            cmd_accept;

    assign cmd_ready_o = !rst_i && (state_q == StIdle || state_q == StWr);
    assign cmd_accept  = cmd_ready_o && cmd_valid_i;

    // Slaves that answer in the same cycle are OR-merged.
    always_comb begin
        rd_merged = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (ic0_c_axi_slv_rd_ready_i[i]) begin
                rd_merged = rd_merged | ic0_axi_slv_rd_data_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_valid_d  = 1'b0;
        rd_addr_d   = rd_addr_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            StIdle, StWr: begin
                if (cmd_accept && cmd_we_i) begin
                    state_d    = StWr;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = cmd_addr_i;
                    wr_data_d  = cmd_wdata_i;
                end else if (cmd_accept) begin
                    state_d    = StRd;
                    rd_valid_d = 1'b1;
                    rd_addr_d  = cmd_addr_i;
                end else begin
                    state_d = StIdle;
                end
            end
            StRd: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                if (|ic0_c_axi_slv_rd_ready_i) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = rd_merged;
                    cnt_d       = '0;
                end else if (cnt_q >= ToLast) begin
                    // This cycle's increment reaches TIMEOUT.
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign ic0_c_axi_mst_wr_valid_o = wr_valid_q;
    assign ic0_axi_mst_wr_addr_o    = wr_addr_q;
    assign ic0_axi_mst_wr_data_o    = wr_data_q;
    assign ic0_c_axi_mst_rd_valid_o = rd_valid_q;
    assign ic0_axi_mst_rd_addr_o    = rd_addr_q;
    assign rsp_valid_o              = rsp_valid_q;
    assign rsp_err_o                = rsp_err_q;
    assign rsp_data_o               = rsp_data_q;

endmodule

// File: tb/tb_ic0_axi_master_seq.sv
// Scoreboard bench for ic0_axi_master_seq: expected writes and read responses are
// queued as commands are issued and popped when the DUT strobes them out.
module tb_ic0_axi_master_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        wr_valid_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        rd_valid_o;
    logic [31:0] rd_addr_o;
    logic [1:0]  slv_ready_i = '0;
    logic [63:0] slv_data_i = '0;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] data; logic err; } rsp_t;
    wr_t  wr_q[$];
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    ic0_axi_master_seq #(.NUM_SLV(2), .TIMEOUT(16), .TO_W(5)) dut (
        .clk_i                    (clk_i),
        .rst_i                    (rst_i),
        .cmd_valid_i              (cmd_valid_i),
        .cmd_ready_o              (cmd_ready_o),
        .cmd_we_i                 (cmd_we_i),
        .cmd_addr_i               (cmd_addr_i),
        .cmd_wdata_i              (cmd_wdata_i),
        .rsp_valid_o              (rsp_valid_o),
        .rsp_data_o               (rsp_data_o),
        .rsp_err_o                (rsp_err_o),
        .ic0_c_axi_mst_wr_valid_o (wr_valid_o),
        .ic0_axi_mst_wr_addr_o    (wr_addr_o),
        .ic0_axi_mst_wr_data_o    (wr_data_o),
        .ic0_c_axi_mst_rd_valid_o (rd_valid_o),
        .ic0_axi_mst_rd_addr_o    (rd_addr_o),
        .ic0_c_axi_slv_rd_ready_i (slv_ready_i),
        .ic0_axi_slv_rd_data_i    (slv_data_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue_read(input logic [31:0] addr);
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = addr;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (cmd_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready_o);
        end
        n_checks++;
        if ({wr_valid_o, rd_valid_o, rsp_valid_o, rsp_err_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {wr_valid_o, rd_valid_o, rsp_valid_o, rsp_err_o});
        end
        n_checks++;
        if ({wr_addr_o, wr_data_o, rd_addr_o, rsp_data_o} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: got nonzero bus/rsp data, expected 0");
        end
        rst_i = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_cmd_ready: got %b expected 1", cmd_ready_o);
        end
    endtask

    task automatic test_write(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_addr_i  = addr;
        cmd_wdata_i = data;
        wr_q.push_back('{addr, data});
        tick();
        cmd_valid_i = 1'b0;
        n_checks++;
        if (wr_valid_o !== 1'b1 || rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL write_strobe: got wr=%b rd=%b expected wr=1 rd=0", wr_valid_o, rd_valid_o);
        end
        e = wr_q.pop_front();
        n_checks++;
        if (wr_addr_o !== e.addr || wr_data_o !== e.data) begin
            n_fail++;
            $display("FAIL write_payload: got %h/%h expected %h/%h", wr_addr_o, wr_data_o, e.addr, e.data);
        end
        tick();
        n_checks++;
        if (wr_valid_o !== 1'b0 || wr_addr_o !== addr) begin
            n_fail++;
            $display("FAIL write_one_cycle: got wr=%b addr=%h expected wr=0 addr=%h", wr_valid_o, wr_addr_o, addr);
        end
    endtask

    task automatic test_back_to_back();
        wr_t e;
        for (int i = 0; i < 3; i++) begin
            cmd_valid_i = 1'b1;
            cmd_we_i    = 1'b1;
            cmd_addr_i  = 32'h500 + 32'(4 * i);
            cmd_wdata_i = 32'h100 + 32'(i);
            wr_q.push_back('{cmd_addr_i, cmd_wdata_i});
            tick();
            e = wr_q.pop_front();
            n_checks++;
            if (wr_valid_o !== 1'b1 || wr_addr_o !== e.addr || wr_data_o !== e.data) begin
                n_fail++;
                $display("FAIL b2b_write%0d: got wr=%b %h/%h expected wr=1 %h/%h",
                         i, wr_valid_o, wr_addr_o, wr_data_o, e.addr, e.data);
            end
        end
        cmd_valid_i = 1'b0;
        tick();
        n_checks++;
        if (wr_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: got wr=%b expected 0", wr_valid_o);
        end
    endtask

    task automatic test_read();
        rsp_t e;
        issue_read(32'h460);
        tick();
        cmd_valid_i = 1'b0;
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_addr_o !== 32'h460 || cmd_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_strobe: got rd=%b addr=%h rdy=%b expected rd=1 addr=460 rdy=0",
                     rd_valid_o, rd_addr_o, cmd_ready_o);
        end
        tick();
        slv_ready_i = 2'b01;
        slv_data_i  = {32'h0, 32'hA};
        rsp_q.push_back('{32'hA, 1'b0});
        n_checks++;
        if (rd_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL read_wait: got rd=%b rsp=%b expected 0/0", rd_valid_o, rsp_valid_o);
        end
        tick();
        slv_ready_i = 2'b00;
        slv_data_i  = '0;
        e = rsp_q.pop_front();
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== e.data || rsp_err_o !== e.err) begin
            n_fail++;
            $display("FAIL read_rsp: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                     rsp_valid_o, rsp_data_o, rsp_err_o, e.data, e.err);
        end
        tick();
        n_checks++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL read_done: got rsp=%b rdy=%b expected 0/1", rsp_valid_o, cmd_ready_o);
        end
    endtask

    task automatic test_timeout();
        rsp_t e;
        int   n;
        int   seen;
        issue_read(32'h470);
        tick();
        cmd_valid_i = 1'b0;
        rsp_q.push_back('{32'h0, 1'b1});
        n = 0;
        while (n < 40 && rsp_valid_o !== 1'b1) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 17) begin
            n_fail++; $display("FAIL timeout_latency: got %0d cycles after rd_valid expected 17", n);
        end
        e = rsp_q.pop_front();
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== e.data || rsp_err_o !== e.err) begin
            n_fail++;
            $display("FAIL timeout_rsp: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                     rsp_valid_o, rsp_data_o, rsp_err_o, e.data, e.err);
        end
        // Late answer after the timeout must be dropped.
        slv_ready_i = 2'b01;
        slv_data_i  = {32'h0, 32'h77};
        tick();
        slv_ready_i = 2'b00;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid_o === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL late_ready_ignored: got %0d rsp pulses expected 0", seen);
        end
    endtask

    task automatic test_reset_mid_read();
        int seen;
        issue_read(32'h480);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_cmd_ready: got %b expected 0", cmd_ready_o);
        end
        tick();
        rst_i       = 1'b0;
        slv_ready_i = 2'b01;
        slv_data_i  = {32'h0, 32'h55};
        tick();
        slv_ready_i = 2'b00;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL rst_mid_no_rsp: got %0d rsp pulses expected 0", seen);
        end
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_ready_after: got %b expected 1", cmd_ready_o);
        end
    endtask

    task automatic test_merge();
        rsp_t e;
        issue_read(32'h490);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        slv_ready_i = 2'b11;
        slv_data_i  = {32'hC, 32'h3};
        rsp_q.push_back('{32'hF, 1'b0});
        tick();
        slv_ready_i = 2'b00;
        slv_data_i  = '0;
        e = rsp_q.pop_front();
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== e.data || rsp_err_o !== e.err) begin
            n_fail++;
            $display("FAIL merge_rsp: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                     rsp_valid_o, rsp_data_o, rsp_err_o, e.data, e.err);
        end
        tick();
    endtask

    task automatic test_wr_then_rd();
        wr_t  w;
        rsp_t e;
        int   n;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_addr_i  = 32'h4A0;
        cmd_wdata_i = 32'h99;
        wr_q.push_back('{32'h4A0, 32'h99});
        tick();
        w = wr_q.pop_front();
        n_checks++;
        if (wr_valid_o !== 1'b1 || wr_addr_o !== w.addr || wr_data_o !== w.data
            || cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_write: got wr=%b %h/%h rdy=%b expected wr=1 %h/%h rdy=1",
                     wr_valid_o, wr_addr_o, wr_data_o, cmd_ready_o, w.addr, w.data);
        end
        issue_read(32'h4A4);
        tick();
        cmd_valid_i = 1'b0;
        n_checks++;
        if (wr_valid_o !== 1'b0 || rd_valid_o !== 1'b1 || rd_addr_o !== 32'h4A4) begin
            n_fail++;
            $display("FAIL wr_rd_read: got wr=%b rd=%b addr=%h expected wr=0 rd=1 addr=4a4",
                     wr_valid_o, rd_valid_o, rd_addr_o);
        end
        rsp_q.push_back('{32'h0, 1'b1});
        n = 0;
        while (n < 40 && rsp_valid_o !== 1'b1) begin
            tick();
            n++;
        end
        e = rsp_q.pop_front();
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== e.data || rsp_err_o !== e.err || n != 17) begin
            n_fail++;
            $display("FAIL wr_rd_rsp: got v=%b d=%h e=%b after %0d expected v=1 d=%h e=%b after 17",
                     rsp_valid_o, rsp_data_o, rsp_err_o, n, e.data, e.err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write(32'h454, 32'h5);
        test_back_to_back();
        test_read();
        test_timeout();
        test_reset_mid_read();
        test_merge();
        test_wr_then_rd();
        n_checks++;
        if (wr_q.size() != 0 || rsp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", wr_q.size(), rsp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
